// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between fetch and data masters.
// An in-flight ID FIFO routes in-order responses back to the issuing master.
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    resp_err_o
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {INSTR = 1'b0, DATA = 1'b1} master_e;

    master_e          sel;
    master_e          last_grant_q, last_grant_d;
    master_e          lock_sel_q, lock_sel_d;
    logic             lock_q, lock_d;
    logic             resp_err_q, resp_err_d;
    master_e          id_q [MAX_OUTSTANDING];
    master_e          id_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, push, pop;

    always_comb begin
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (last_grant_q == INSTR) ? DATA : INSTR;
        end else if (data_req_i) begin
            sel = DATA;
        end else begin
            sel = INSTR;
        end
    end

    assign full        = (count_q == MAX_CNT);
    assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
    assign mem_addr_o  = (sel == DATA) ? data_addr_i : instr_addr_i;
    assign mem_we_o    = (sel == DATA) & data_we_i;
    assign mem_be_o    = (sel == DATA) ? data_be_i : '1;
    assign mem_wdata_o = data_wdata_i;

    assign push        = mem_req_o & mem_gnt_i;
    assign pop         = mem_rvalid_i & (count_q != '0);
    assign instr_gnt_o = push & (sel == INSTR);
    assign data_gnt_o  = push & (sel == DATA);

    // Responses are in order, so the FIFO head names the owner combinationally.
    assign instr_rvalid_o = pop & (id_q[rptr_q] == INSTR);
    assign data_rvalid_o  = pop & (id_q[rptr_q] == DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign resp_err_o     = resp_err_q;

    always_comb begin
        lock_d       = lock_q;
        lock_sel_d   = lock_sel_q;
        last_grant_d = last_grant_q;
        resp_err_d   = resp_err_q | (mem_rvalid_i & (count_q == '0));
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        id_d         = id_q;
        if (mem_req_o && !mem_gnt_i) begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
        end else if (push) begin
            lock_d = 1'b0;
        end
        if (push) begin
            last_grant_d = sel;
            id_d[wptr_q] = sel;
            wptr_d       = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q       <= 1'b0;
            lock_sel_q   <= INSTR;
            last_grant_q <= INSTR;
            resp_err_q   <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_q[i] <= INSTR;
            end
        end else begin
            lock_q       <= lock_d;
            lock_sel_q   <= lock_sel_d;
            last_grant_q <= last_grant_d;
            resp_err_q   <= resp_err_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            id_q         <= id_d;
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed self-checking bench for obi_mem_arbiter.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_obi_mem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        resp_err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    obi_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i),
        .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .resp_err_o(resp_err_o)
    );

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da,
                         input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk_i);
        instr_req_i  = ir;
        instr_addr_i = ia;
        data_req_i   = dr;
        data_addr_i  = da;
        mem_gnt_i    = g;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_addr_i = 0;
        data_we_i = 0; data_be_i = 4'hF; data_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_req_o, resp_err_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, mem_req_o, resp_err_o});
        end
    endtask

    task automatic test_solo_fetch();
        do_reset();
        drive(1, 32'h180, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b110) begin
            n_bad++;
            $display("FAIL fetch_gnt: got %b want 110", {mem_req_o, instr_gnt_o, data_gnt_o});
        end
        n_cmp++;
        if ({mem_addr_o, mem_we_o, mem_be_o} !== {32'h180, 1'b0, 4'hF}) begin
            n_bad++;
            $display("FAIL fetch_memout: got %h/%b/%h want 180/0/f", mem_addr_o, mem_we_o, mem_be_o);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h13);
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'h13}) begin
            n_bad++;
            $display("FAIL fetch_resp: got %b%b %h want 10 00000013",
                     instr_rvalid_o, data_rvalid_o, instr_rdata_o);
        end
    endtask

    task automatic test_conflict();
        logic exp_d;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 32'h100, k < 4, 32'h200, k < 4, k > 0, 32'(k));
            exp_d = (k % 2 == 0);
            if (k < 4) begin
                n_cmp++;
                if ({data_gnt_o, instr_gnt_o} !== {exp_d, ~exp_d}
                    || mem_addr_o !== (exp_d ? 32'h200 : 32'h100)) begin
                    n_bad++;
                    $display("FAIL conflict_gnt%0d: got d%b i%b a%h want d%b i%b",
                             k, data_gnt_o, instr_gnt_o, mem_addr_o, exp_d, ~exp_d);
                end
            end
            if (k > 0) begin
                exp_d = ((k - 1) % 2 == 0);
                n_cmp++;
                if ({data_rvalid_o, instr_rvalid_o} !== {exp_d, ~exp_d}
                    || data_rdata_o !== 32'(k)) begin
                    n_bad++;
                    $display("FAIL conflict_resp%0d: got d%b i%b want d%b i%b",
                             k, data_rvalid_o, instr_rvalid_o, exp_d, ~exp_d);
                end
            end
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h300, k == 2, 32'h400, 0, 0, 0);
            n_cmp++;
            if ({mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o} !== {1'b1, 32'h300, 2'b00}) begin
                n_bad++;
                $display("FAIL lock_stall%0d: got req%b a%h ig%b dg%b want req1 a300 00",
                         k, mem_req_o, mem_addr_o, instr_gnt_o, data_gnt_o);
            end
        end
        drive(1, 32'h300, 1, 32'h400, 1, 0, 0);
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o, mem_addr_o} !== {2'b10, 32'h300}) begin
            n_bad++;
            $display("FAIL lock_first: got ig%b dg%b a%h want 10 300", instr_gnt_o, data_gnt_o, mem_addr_o);
        end
        drive(0, 0, 1, 32'h400, 1, 1, 32'hA);
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o, mem_addr_o, instr_rvalid_o} !== {2'b01, 32'h400, 1'b1}) begin
            n_bad++;
            $display("FAIL lock_second: got ig%b dg%b a%h irv%b want 01 400 1",
                     instr_gnt_o, data_gnt_o, mem_addr_o, instr_rvalid_o);
        end
        drive(0, 0, 0, 0, 0, 1, 32'hB);
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL lock_resp: got %b%b want 01", instr_rvalid_o, data_rvalid_o);
        end
    endtask

    task automatic test_full();
        do_reset();
        drive(1, 32'h500, 0, 0, 1, 0, 0);
        drive(0, 0, 1, 32'h600, 1, 0, 0);
        n_cmp++;
        if (data_gnt_o !== 1'b1) begin
            n_bad++;
            $display("FAIL full_second_gnt: got %b want 1", data_gnt_o);
        end
        drive(1, 32'h700, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({mem_req_o, instr_gnt_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL full_block: got req%b gnt%b want 00", mem_req_o, instr_gnt_o);
        end
        drive(1, 32'h700, 0, 0, 1, 1, 32'h1);
        n_cmp++;
        if ({mem_req_o, instr_gnt_o, instr_rvalid_o} !== 3'b001) begin
            n_bad++;
            $display("FAIL full_pop: got req%b gnt%b rv%b want 001", mem_req_o, instr_gnt_o, instr_rvalid_o);
        end
        drive(1, 32'h700, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({mem_req_o, instr_gnt_o, mem_addr_o} !== {2'b11, 32'h700}) begin
            n_bad++;
            $display("FAIL full_resume: got req%b gnt%b a%h want 11 700", mem_req_o, instr_gnt_o, mem_addr_o);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h2);
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL full_resp_d: got %b%b want 01", instr_rvalid_o, data_rvalid_o);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h3);
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL full_resp_i: got %b%b want 10", instr_rvalid_o, data_rvalid_o);
        end
    endtask

    task automatic test_write();
        do_reset();
        data_we_i = 1; data_be_i = 4'b0011; data_wdata_i = 32'hDEADBEEF;
        drive(0, 0, 1, 32'h800, 1, 0, 0);
        n_cmp++;
        if ({data_gnt_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o}
            !== {2'b11, 4'b0011, 32'hDEADBEEF, 32'h800}) begin
            n_bad++;
            $display("FAIL write_memout: got g%b we%b be%b wd%h a%h want 1 1 0011 deadbeef 800",
                     data_gnt_o, mem_we_o, mem_be_o, mem_wdata_o, mem_addr_o);
        end
        data_we_i = 0; data_be_i = 4'hF;
        drive(0, 0, 0, 0, 0, 1, 0);
        n_cmp++;
        if ({data_rvalid_o, instr_rvalid_o} !== 2'b10) begin
            n_bad++;
            $display("FAIL write_resp: got d%b i%b want 10", data_rvalid_o, instr_rvalid_o);
        end
    endtask

    task automatic test_errors();
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 32'h55);
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o, resp_err_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL err_unexp: got %b%b%b want 000", instr_rvalid_o, data_rvalid_o, resp_err_o);
        end
        drive(1, 32'h900, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({resp_err_o, instr_gnt_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL err_sticky: got err%b gnt%b want 11", resp_err_o, instr_gnt_o);
        end
        @(negedge clk_i);
        instr_req_i = 0; mem_gnt_i = 0;
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        #1;
        n_cmp++;
        if (resp_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_reset: got %b want 0", resp_err_o);
        end
        drive(0, 0, 0, 0, 0, 1, 32'h66);
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL err_flushed: got %b%b want 00", instr_rvalid_o, data_rvalid_o);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (resp_err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL err_after_reset: got %b want 1", resp_err_o);
        end
    endtask

    initial begin
        test_reset();
        test_solo_fetch();
        test_conflict();
        test_lock();
        test_full();
        test_write();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/obi_mem_arbiter.md
Name: obi_mem_arbiter

Overview:
- Shares one single-port, OBI-style memory port between the core's instruction-fetch and data-access masters.
- Arbitrates between the two masters with round-robin priority.
- Keeps a grant request stable while the memory has not yet accepted it.
- Tracks in-flight transactions in an ID FIFO so each in-order memory response is routed back to the master that issued it.
- Sits between cv32e40p_top and the memory model (mm_ram) in the testbench subsystem.

Parameters:
- ADDR_WIDTH, 32: address width of both masters and the memory port.
- DATA_WIDTH, 32: read and write data width.
- MAX_OUTSTANDING, 2: depth of the in-flight ID FIFO; range 1..8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- instr_req_i  in  1  instruction master request.
- instr_addr_i  in  ADDR_WIDTH  instruction address (read-only master).
- instr_gnt_o  out  1  instruction request accepted.
- instr_rvalid_o  out  1  instruction response valid.
- instr_rdata_o  out  DATA_WIDTH  instruction read data.
- data_req_i  in  1  data master request.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_we_i  in  1  write enable.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_gnt_o  out  1  data request accepted.
- data_rvalid_o  out  1  data response valid (returned for writes too).
- data_rdata_o  out  DATA_WIDTH  data read data.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  ADDR_WIDTH  memory address.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_WIDTH/8  memory byte enables.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response valid; responses return in order.
- mem_rdata_i  in  DATA_WIDTH  memory read data.
- resp_err_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:

Clock and reset
- Single clock, clk_i.
- Reset rst_i is synchronous and active-high. It clears:
  - the FIFO and its count (count=0);
  - lock=0;
  - last_grant=INSTR;
  - resp_err_o=0.
- Reset asserted mid-transaction discards all outstanding IDs. Responses arriving after reset, with the FIFO empty, set resp_err_o.

Grant selection (combinational)
- Only the instruction master requesting: select INSTR.
- Only the data master requesting: select DATA.
- Both requesting: select the master that is not last_grant. The first conflict after reset therefore goes to DATA.
- If lock=1, the selection is held at the previously selected master regardless of new requests.

Memory request and grants
- full = (count == MAX_OUTSTANDING).
- mem_req_o = (instr_req_i | data_req_i) & !full.
- mem_addr/we/be/wdata are muxed from the selected master.
  - INSTR forces we=0 and be=all ones.
  - Outputs are undefined while mem_req_o=0 (bench must not check them then).
- instr_gnt_o = mem_gnt_i & mem_req_o & sel==INSTR. data_gnt_o is analogous. At most one grant per cycle.

Lock register
- Set when mem_req_o=1 and mem_gnt_i=0: holds the selection so the memory sees a stable request.
- Cleared on the handshake.
- When full=1, the request is withheld and lock is unchanged.

On a handshake (mem_req_o & mem_gnt_i)
- Push the selected ID into the FIFO.
- last_grant <= sel.
- Zero-cycle grant: gnt may occur in the same cycle req rises.

On mem_rvalid_i
- If count>0: pop the head ID and assert exactly one of instr_rvalid_o / data_rvalid_o in that same cycle (combinational routing, zero added latency).
- instr_rdata_o and data_rdata_o both carry mem_rdata_i.
- If count==0: no rvalid is asserted and resp_err_o <= 1 (sticky until reset).

Simultaneous push and pop
- count is unchanged; the FIFO order is preserved.
- A push cannot occur while full. A pop in the same cycle does not unblock the request; the request resumes the next cycle.

FIFO
- Circular buffer with read/write pointers that wrap modulo MAX_OUTSTANDING.
- count width is $clog2(MAX_OUTSTANDING+1).

Reset values of outputs
- All gnt/rvalid outputs = 0.
- mem_req_o = 0 unless a request input is high.
- resp_err_o = 0.

Test Plan:
1. Solo fetch:
   - Stimulus: instr_req=1, addr=0x180, mem_gnt=1 immediately, mem_rvalid next cycle with rdata=0x00000013.
   - Required: instr_gnt same cycle; instr_rvalid=1 with 0x00000013 one cycle later; data_rvalid stays 0.
2. Conflict:
   - Stimulus: both masters request continuously from reset, mem_gnt=1 every cycle.
   - Required: grants alternate DATA, INSTR, DATA, INSTR; responses routed in the same order.
3. Lock:
   - Stimulus: instr requests, mem_gnt=0 for 3 cycles, data_req rises in cycle 2.
   - Required: mem_addr stays equal to instr_addr through all stall cycles; instr is granted first, data is granted next.
4. Full:
   - Stimulus: MAX_OUTSTANDING=2, two grants with rvalid withheld.
   - Required: mem_req_o=0 while a third request is pending; on the first rvalid the pop occurs, and the third request is granted the following cycle.
5. Write:
   - Stimulus: data_we=1, be=4'b0011, wdata=0xDEADBEEF.
   - Required: mem outputs match the data master's inputs; data_rvalid asserted on the response.
6. Errors and reset:
   - Stimulus: mem_rvalid with count=0, then a reset pulse mid-transaction.
   - Required: resp_err_o=1 and no rvalid on the unexpected response; after reset resp_err_o=0 and count=0.
